pll_scan_engine: RTL and testbench

// Responder side of the PLL reconfiguration handshake: accepts counter write/read/reconfig requests
// (counter_type/counter_param/data_in/write_param/read_param/reconfig, busy/data_out) from the sweep controller.

---
 rtl/pll_cfg_pkg.sv | 45 ++++
 rtl/pll_count_decode.sv | 25 ++
 rtl/pll_scan_engine.sv | 190 +++++++++++++++++++
 tb/tb_pll_scan_engine.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL scan-chain reconfiguration engine:
// counter/parameter codes, shadow field layout and FSM states.
package pll_cfg_pkg;

  localparam logic [3:0] CT_N  = 4'd0;
  localparam logic [3:0] CT_M  = 4'd1;
  localparam logic [3:0] CT_C0 = 4'd4;

  localparam logic [2:0] PARAM_HI  = 3'd0;
  localparam logic [2:0] PARAM_LO  = 3'd1;
  localparam logic [2:0] PARAM_BYP = 3'd4;
  localparam logic [2:0] PARAM_ODD = 3'd5;
  localparam logic [2:0] PARAM_NOM = 3'd7;

  localparam int unsigned SCAN_LEN = 54;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       byp;
    logic       odd;
  } cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR2,
    S_RD,
    S_RD2,
    S_SHIFT,
    S_UPDATE,
    S_WAIT_DONE
  } state_t;

  // Shadow slot in image order {N, M, C0}; 3 marks an unsupported counter.
  function automatic logic [1:0] ctr_slot(input logic [3:0] ct);
    case (ct)
      CT_N:    return 2'd2;
      CT_M:    return 2'd1;
      CT_C0:   return 2'd0;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/pll_count_decode.sv
// Nominal division count -> {hi, lo, byp, odd} decoder for one PLL counter.
module pll_count_decode
  import pll_cfg_pkg::*;
(
  input  logic [8:0] count_i,
  output cnt_t       fields_o
);

  logic [8:0] v;

  always_comb begin
    fields_o = '0;
    v        = (count_i > 9'd510) ? 9'd510 : count_i;
    if (count_i <= 9'd1) begin
      fields_o.byp = 1'b1;
      fields_o.hi  = 8'd1;
      fields_o.lo  = 8'd1;
    end else begin
      fields_o.hi  = 8'((v + 9'd1) >> 1);
      fields_o.lo  = v[8:1];
      fields_o.odd = v[0];
    end
  end

endmodule

// File: rtl/pll_scan_engine.sv
// Responder for counter write/read/reconfig requests; keeps the N/M/C0 shadow
// image and shifts it MSB-first into the PLL scan chain.
module pll_scan_engine #(
  parameter int unsigned N_INIT   = 25,
  parameter int unsigned M_INIT   = 100,
  parameter int unsigned C0_INIT  = 2,
  parameter int unsigned DONE_TMO = 1023
) (
  input  logic       CLK_50,
  input  logic       reset,
  input  logic [3:0] counter_type,
  input  logic [2:0] counter_param,
  input  logic [8:0] data_in,
  input  logic       write_param,
  input  logic       read_param,
  input  logic       reconfig,
  input  logic       pll_areset_in,
  input  logic       pll_scandataout,
  input  logic       pll_scandone,
  output logic       busy,
  output logic [8:0] data_out,
  output logic       pll_scanclk,
  output logic       pll_scanclkena,
  output logic       pll_scandata,
  output logic       pll_configupdate,
  output logic       pll_areset
);
  import pll_cfg_pkg::*;

  localparam int unsigned TMO_W = $clog2(DONE_TMO + 1);

  state_t              state_q, state_d;
  cnt_t   [2:0]        shadow_q, shadow_d;
  logic [SCAN_LEN-1:0] sr_q, sr_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic                phase_q, phase_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [3:0]          req_type_q, req_type_d;
  logic [2:0]          req_param_q, req_param_d;
  logic [8:0]          req_data_q, req_data_d;
  logic [8:0]          data_out_q, data_out_d;
  logic                areset_q;
  logic                unused_scandataout;

  cnt_t       init_n, init_m, init_c0, wr_nom, cur, upd;
  logic [1:0] slot;
  logic [8:0] rd_val;

  assign unused_scandataout = pll_scandataout;

  pll_count_decode u_dec_n  (.count_i(9'(N_INIT)),  .fields_o(init_n));
  pll_count_decode u_dec_m  (.count_i(9'(M_INIT)),  .fields_o(init_m));
  pll_count_decode u_dec_c0 (.count_i(9'(C0_INIT)), .fields_o(init_c0));
  pll_count_decode u_dec_wr (.count_i(req_data_q),  .fields_o(wr_nom));

  always_ff @(posedge CLK_50) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (reconfig)         state_d = S_SHIFT;
        else if (write_param) state_d = S_WR;
        else if (read_param)  state_d = S_RD;
      end
      S_WR:  state_d = S_WR2;
      S_WR2: state_d = S_IDLE;
      S_RD:  state_d = S_RD2;
      S_RD2: state_d = S_IDLE;
      S_SHIFT:
        if (phase_q && bit_cnt_q == 6'(SCAN_LEN - 1)) state_d = S_UPDATE;
      S_UPDATE:
        if (phase_q) state_d = S_WAIT_DONE;
      S_WAIT_DONE:
        if (pll_scandone || tmo_q == TMO_W'(DONE_TMO - 1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy             = (state_q != S_IDLE);
    pll_scanclkena   = (state_q == S_SHIFT);
    pll_scanclk      = (state_q == S_SHIFT) && phase_q;
    pll_scandata     = (state_q == S_SHIFT) && sr_q[SCAN_LEN-1];
    pll_configupdate = (state_q == S_UPDATE);
    data_out         = data_out_q;
    pll_areset       = areset_q;
  end

  // Field access for the latched request; unsupported counters read as zero.
  always_comb begin
    slot = ctr_slot(req_type_q);
    cur  = '0;
    case (slot)
      2'd0:    cur = shadow_q[0];
      2'd1:    cur = shadow_q[1];
      2'd2:    cur = shadow_q[2];
      default: cur = '0;
    endcase
    upd    = cur;
    rd_val = '0;
    case (req_param_q)
      PARAM_HI:  begin upd.hi  = req_data_q[7:0]; rd_val = {1'b0, cur.hi};  end
      PARAM_LO:  begin upd.lo  = req_data_q[7:0]; rd_val = {1'b0, cur.lo};  end
      PARAM_BYP: begin upd.byp = req_data_q[0];   rd_val = {8'b0, cur.byp}; end
      PARAM_ODD: begin upd.odd = req_data_q[0];   rd_val = {8'b0, cur.odd}; end
      PARAM_NOM: begin
        upd    = wr_nom;
        rd_val = cur.byp ? 9'd1 : ({1'b0, cur.hi} + {1'b0, cur.lo});
      end
      default: ;
    endcase
    if (slot == 2'd3) rd_val = '0;
  end

  always_comb begin
    shadow_d    = shadow_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    phase_d     = phase_q;
    tmo_d       = tmo_q;
    req_type_d  = req_type_q;
    req_param_d = req_param_q;
    req_data_d  = req_data_q;
    data_out_d  = data_out_q;
    case (state_q)
      S_IDLE: begin
        phase_d   = 1'b0;
        bit_cnt_d = '0;
        tmo_d     = '0;
        if (reconfig) begin
          sr_d = shadow_q;
        end else if (write_param || read_param) begin
          req_type_d  = counter_type;
          req_param_d = counter_param;
          req_data_d  = data_in;
        end
      end
      S_WR: begin
        for (int unsigned i = 0; i < 3; i++)
          if (slot == 2'(i)) shadow_d[i] = upd;
      end
      S_RD: data_out_d = rd_val;
      // Data advances on the scanclk falling edge so it is stable at the rising edge.
      S_SHIFT: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          sr_d      = {sr_q[SCAN_LEN-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      S_UPDATE: begin
        phase_d = ~phase_q;
        tmo_d   = '0;
      end
      S_WAIT_DONE: tmo_d = tmo_q + TMO_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      shadow_q    <= {init_n, init_m, init_c0};
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      phase_q     <= 1'b0;
      tmo_q       <= '0;
      req_type_q  <= '0;
      req_param_q <= '0;
      req_data_q  <= '0;
      data_out_q  <= '0;
      areset_q    <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      phase_q     <= phase_d;
      tmo_q       <= tmo_d;
      req_type_q  <= req_type_d;
      req_param_q <= req_param_d;
      req_data_q  <= req_data_d;
      data_out_q  <= data_out_d;
      areset_q    <= pll_areset_in;
    end
  end

endmodule

// File: tb/tb_pll_scan_engine.sv
// Self-checking bench for pll_scan_engine against a behavioural counter model.
module tb_pll_scan_engine;

  localparam int N_INIT   = 25;
  localparam int M_INIT   = 100;
  localparam int C0_INIT  = 2;
  localparam int DONE_TMO = 1023;

  logic       CLK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] counter_type = '0;
  logic [2:0] counter_param = '0;
  logic [8:0] data_in = '0;
  logic       write_param = 1'b0;
  logic       read_param = 1'b0;
  logic       reconfig = 1'b0;
  logic       pll_areset_in = 1'b0;
  logic       pll_scandataout = 1'b0;
  logic       pll_scandone = 1'b0;
  logic       busy;
  logic [8:0] data_out;
  logic       pll_scanclk, pll_scanclkena, pll_scandata, pll_configupdate, pll_areset;

  int n_checks = 0;
  int n_fail = 0;

  int m_hi[3], m_lo[3], m_byp[3], m_odd[3];

  pll_scan_engine #(
    .N_INIT(N_INIT), .M_INIT(M_INIT), .C0_INIT(C0_INIT), .DONE_TMO(DONE_TMO)
  ) dut (
    .CLK_50(CLK_50), .reset(reset), .counter_type(counter_type),
    .counter_param(counter_param), .data_in(data_in), .write_param(write_param),
    .read_param(read_param), .reconfig(reconfig), .pll_areset_in(pll_areset_in),
    .pll_scandataout(pll_scandataout), .pll_scandone(pll_scandone), .busy(busy),
    .data_out(data_out), .pll_scanclk(pll_scanclk), .pll_scanclkena(pll_scanclkena),
    .pll_scandata(pll_scandata), .pll_configupdate(pll_configupdate),
    .pll_areset(pll_areset)
  );

  always #10 CLK_50 = ~CLK_50;

  initial begin
    #4000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int cidx(input int t);
    case (t)
      0: return 0;
      1: return 1;
      4: return 2;
      default: return -1;
    endcase
  endfunction

  function automatic void m_write(input int t, input int p, input int d);
    int c, v;
    c = cidx(t);
    if (c < 0) return;
    case (p)
      0: m_hi[c] = d % 256;
      1: m_lo[c] = d % 256;
      4: m_byp[c] = d % 2;
      5: m_odd[c] = d % 2;
      7: begin
        if (d <= 1) begin
          m_byp[c] = 1; m_hi[c] = 1; m_lo[c] = 1; m_odd[c] = 0;
        end else begin
          v = (d > 510) ? 510 : d;
          m_hi[c] = (v + 1) / 2; m_lo[c] = v / 2; m_odd[c] = v % 2; m_byp[c] = 0;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic int m_read(input int t, input int p);
    int c;
    c = cidx(t);
    if (c < 0) return 0;
    case (p)
      0: return m_hi[c];
      1: return m_lo[c];
      4: return m_byp[c];
      5: return m_odd[c];
      7: return (m_byp[c] != 0) ? 1 : m_hi[c] + m_lo[c];
      default: return 0;
    endcase
  endfunction

  function automatic void m_reset();
    m_write(0, 7, N_INIT);
    m_write(1, 7, M_INIT);
    m_write(4, 7, C0_INIT);
  endfunction

  function automatic logic [53:0] m_image();
    logic [53:0] img;
    int k;
    img = '0;
    k = 53;
    for (int c = 0; c < 3; c++) begin
      for (int b = 7; b >= 0; b--) begin img[k] = 1'((m_hi[c] >> b) & 1); k--; end
      for (int b = 7; b >= 0; b--) begin img[k] = 1'((m_lo[c] >> b) & 1); k--; end
      img[k] = 1'(m_byp[c]); k--;
      img[k] = 1'(m_odd[c]); k--;
    end
    return img;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic op(input bit wr, input bit rd, input bit rc, input int t, input int p, input int d);
    counter_type  = 4'(t);
    counter_param = 3'(p);
    data_in       = 9'(d);
    write_param   = wr;
    read_param    = rd;
    reconfig      = rc;
    tick();
    write_param = 1'b0;
    read_param  = 1'b0;
    reconfig    = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic do_write(input int t, input int p, input int d, output int blen);
    op(1'b1, 1'b0, 1'b0, t, p, d);
    wait_busy(blen);
  endtask

  task automatic do_read(input int t, input int p, output int blen, output int val);
    op(1'b0, 1'b1, 1'b0, t, p, 0);
    wait_busy(blen);
    val = int'(data_out);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_reset();
  endtask

  // Follows SHIFT and UPDATE from the first SHIFT cycle until configupdate falls.
  task automatic shift_capture(input int wr_at, output logic [53:0] cap, output int rises,
                               output int cu, output int ena_bad, output bit found);
    bit prev_clk, prev_cu;
    prev_clk = 1'b0; prev_cu = 1'b0;
    cap = '0; rises = 0; cu = 0; ena_bad = 0; found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (pll_scanclk && !prev_clk) begin
        cap = {cap[52:0], pll_scandata};
        rises++;
      end
      if (pll_scanclk && !pll_scanclkena) ena_bad++;
      if (pll_configupdate) cu++;
      if (prev_cu && !pll_configupdate) begin
        found = 1'b1;
      end else begin
        prev_clk = pll_scanclk;
        prev_cu  = pll_configupdate;
        if (i == wr_at) begin
          counter_type = 4'd1; counter_param = 3'd7; data_in = 9'd200; write_param = 1'b1;
        end
        tick();
        write_param = 1'b0;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bl, v;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (data_out !== 9'd0) begin n_fail++; $display("FAIL rst_data_out: got %0d expected 0", data_out); end
    n_checks++; if ({pll_scanclk, pll_scanclkena, pll_scandata, pll_configupdate, pll_areset} !== 5'b0) begin
      n_fail++; $display("FAIL rst_pll_outs: got %b expected 00000",
                         {pll_scanclk, pll_scanclkena, pll_scandata, pll_configupdate, pll_areset});
    end
    reset = 1'b0;
    m_reset();
    foreach (m_hi[c]) begin
      int t;
      t = (c == 0) ? 0 : (c == 1) ? 1 : 4;
      for (int p = 0; p < 8; p++) begin
        if (p == 0 || p == 1 || p == 4 || p == 5 || p == 7) begin
          do_read(t, p, bl, v);
          n_checks++; if (v !== m_read(t, p)) begin
            n_fail++; $display("FAIL rst_shadow t=%0d p=%0d: got %0d expected %0d", t, p, v, m_read(t, p));
          end
        end
      end
    end
  endtask

  task automatic test_write_read();
    int bl, v;
    int rp[4] = '{7, 0, 1, 5};
    do_write(1, 7, 101, bl); m_write(1, 7, 101);
    n_checks++; if (bl !== 2) begin n_fail++; $display("FAIL wr_busy_len: got %0d expected 2", bl); end
    foreach (rp[i]) begin
      do_read(1, rp[i], bl, v);
      n_checks++; if (v !== m_read(1, rp[i])) begin
        n_fail++; $display("FAIL rd_M p=%0d: got %0d expected %0d", rp[i], v, m_read(1, rp[i]));
      end
      n_checks++; if (bl !== 2) begin n_fail++; $display("FAIL rd_busy_len: got %0d expected 2", bl); end
    end
    do_write(0, 7, 1, bl); m_write(0, 7, 1);
    do_read(0, 4, bl, v);
    n_checks++; if (v !== m_read(0, 4)) begin n_fail++; $display("FAIL rd_N_byp: got %0d expected %0d", v, m_read(0, 4)); end
    do_read(0, 7, bl, v);
    n_checks++; if (v !== m_read(0, 7)) begin n_fail++; $display("FAIL rd_N_nom1: got %0d expected %0d", v, m_read(0, 7)); end
    do_write(0, 7, 511, bl); m_write(0, 7, 511);
    do_read(0, 7, bl, v);
    n_checks++; if (v !== m_read(0, 7)) begin n_fail++; $display("FAIL rd_N_clamp: got %0d expected %0d", v, m_read(0, 7)); end
    do_write(2, 0, 77, bl);
    n_checks++; if (bl !== 2) begin n_fail++; $display("FAIL wr_unsup_busy_len: got %0d expected 2", bl); end
    do_write(0, 3, 77, bl);
    do_read(0, 3, bl, v);
    n_checks++; if (v !== 0) begin n_fail++; $display("FAIL rd_unsup_param: got %0d expected 0", v); end
    do_read(0, 0, bl, v);
    n_checks++; if (v !== m_read(0, 0)) begin n_fail++; $display("FAIL rd_N_hi_after_unsup: got %0d expected %0d", v, m_read(0, 0)); end
  endtask

  task automatic test_random();
    int bl, v, t, p, d, sel;
    int edge_vals[6] = '{0, 1, 2, 509, 510, 511};
    repeat (80) begin
      sel = $urandom_range(0, 4);
      t = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 4 : $urandom_range(0, 15);
      p = $urandom_range(0, 7);
      d = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom_range(0, 511);
      if ($urandom_range(0, 1) == 1) begin
        do_write(t, p, d, bl); m_write(t, p, d);
        n_checks++; if (bl !== 2) begin n_fail++; $display("FAIL rnd_wr_busy t=%0d p=%0d: got %0d expected 2", t, p, bl); end
      end else begin
        do_read(t, p, bl, v);
        n_checks++; if (v !== m_read(t, p)) begin
          n_fail++; $display("FAIL rnd_rd t=%0d p=%0d: got %0d expected %0d", t, p, v, m_read(t, p));
        end
      end
    end
  endtask

  task automatic test_reconfig_done();
    logic [53:0] cap;
    int rises, cu, ena_bad;
    bit found;
    apply_reset();
    op(1'b0, 1'b0, 1'b1, 0, 0, 0);
    shift_capture(-1, cap, rises, cu, ena_bad, found);
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rc_update_seen: got %b expected 1", found); end
    n_checks++; if (rises !== 54) begin n_fail++; $display("FAIL rc_scanclk_rises: got %0d expected 54", rises); end
    n_checks++; if (cap !== m_image()) begin n_fail++; $display("FAIL rc_image: got %h expected %h", cap, m_image()); end
    n_checks++; if (cu !== 2) begin n_fail++; $display("FAIL rc_update_len: got %0d expected 2", cu); end
    n_checks++; if (ena_bad !== 0) begin n_fail++; $display("FAIL rc_scanclkena: got %0d bad cycles expected 0", ena_bad); end
    repeat (10) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rc_busy_wait: got %b expected 1", busy); end
    pll_scandone = 1'b1;
    tick();
    pll_scandone = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rc_busy_after_done: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    logic [53:0] cap;
    int rises, cu, ena_bad, n, bl, v;
    bit found;
    op(1'b0, 1'b0, 1'b1, 0, 0, 0);
    shift_capture(-1, cap, rises, cu, ena_bad, found);
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL tmo_update_seen: got %b expected 1", found); end
    wait_busy(n);
    n_checks++; if (n !== DONE_TMO) begin n_fail++; $display("FAIL tmo_wait_len: got %0d expected %0d", n, DONE_TMO); end
    for (int t = 0; t < 5; t++) begin
      if (cidx(t) >= 0) begin
        do_read(t, 7, bl, v);
        n_checks++; if (v !== m_read(t, 7)) begin
          n_fail++; $display("FAIL tmo_shadow t=%0d: got %0d expected %0d", t, v, m_read(t, 7));
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [53:0] cap;
    int rises, cu, ena_bad, bl, v, pre;
    bit found;
    apply_reset();
    do_read(4, 4, bl, pre);
    n_checks++; if (pre !== m_read(4, 4)) begin n_fail++; $display("FAIL pri_pre_read: got %0d expected %0d", pre, m_read(4, 4)); end
    op(1'b1, 1'b1, 1'b1, 1, 7, 300);
    shift_capture(10, cap, rises, cu, ena_bad, found);
    n_checks++; if (rises !== 54) begin n_fail++; $display("FAIL pri_reconfig_rises: got %0d expected 54", rises); end
    n_checks++; if (cap !== m_image()) begin n_fail++; $display("FAIL pri_image: got %h expected %h", cap, m_image()); end
    n_checks++; if (int'(data_out) !== pre) begin n_fail++; $display("FAIL pri_read_dropped: got %0d expected %0d", data_out, pre); end
    pll_scandone = 1'b1;
    tick();
    pll_scandone = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pri_busy_after_done: got %b expected 0", busy); end
    do_read(1, 7, bl, v);
    n_checks++; if (v !== m_read(1, 7)) begin n_fail++; $display("FAIL pri_write_dropped: got %0d expected %0d", v, m_read(1, 7)); end
  endtask

  task automatic test_reset_mid_shift();
    int bl, v, rises, i;
    bit prev;
    do_write(4, 7, 50, bl); m_write(4, 7, 50);
    do_read(4, 7, bl, v);
    n_checks++; if (v !== m_read(4, 7)) begin n_fail++; $display("FAIL rms_pre_write: got %0d expected %0d", v, m_read(4, 7)); end
    op(1'b0, 1'b0, 1'b1, 0, 0, 0);
    rises = 0; prev = 1'b0; i = 0;
    while (rises < 20 && i < 200) begin
      if (pll_scanclk && !prev) rises++;
      prev = pll_scanclk;
      if (rises < 20) tick();
      i++;
    end
    n_checks++; if (rises !== 20) begin n_fail++; $display("FAIL rms_reach_bit20: got %0d expected 20", rises); end
    reset = 1'b1;
    tick();
    n_checks++; if ({busy, pll_scanclkena, pll_scanclk} !== 3'b000) begin
      n_fail++; $display("FAIL rms_outputs: got %b expected 000", {busy, pll_scanclkena, pll_scanclk});
    end
    reset = 1'b0;
    m_reset();
    do_read(4, 7, bl, v);
    n_checks++; if (v !== m_read(4, 7)) begin n_fail++; $display("FAIL rms_c0_nom: got %0d expected %0d", v, m_read(4, 7)); end
  endtask

  task automatic test_areset();
    pll_areset_in = 1'b1;
    tick();
    n_checks++; if (pll_areset !== 1'b1) begin n_fail++; $display("FAIL areset_rise: got %b expected 1", pll_areset); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_no_busy: got %b expected 0", busy); end
    pll_areset_in = 1'b0;
    tick();
    n_checks++; if (pll_areset !== 1'b0) begin n_fail++; $display("FAIL areset_fall: got %b expected 0", pll_areset); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_random();
    test_reconfig_done();
    test_timeout();
    test_priority();
    test_reset_mid_shift();
    test_areset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
